dco_div: RTL and testbench

DCO_DIV -- requirements
Module: dco_div

---
 rtl/dpll_pkg.sv | 15 +
 rtl/dco_corr_ctl.sv | 63 ++++++
 rtl/dco_div.sv | 157 +++++++++++++++
 tb/tb_dco_div.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpll_pkg.sv
// Shared DPLL types: correction operation encoding and correction direction codes.
package dpll_pkg;

  // Operation applied to the DCO counter in the current cycle.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    ADV  = 2'd1,
    RET  = 2'd2
  } corr_op_t;

  // corr_dir encoding: advance shortens the half-period, retard lengthens it.
  localparam logic CORR_ADV = 1'b0;
  localparam logic CORR_RET = 1'b1;

endpackage

// File: rtl/dco_corr_ctl.sv
// Phase-correction control for dco_div: ready/valid handshake, one-deep pending
// register and a lock that allows at most one correction per clk_out half-period.
// Ports:
//   clk, reset_n    clock, synchronous active-low reset
//   phase_clr_i     realign strobe (drops pending, clears lock, blocks accept)
//   active_i        divider running (half_q != 0)
//   toggle_i        clk_out toggles at the coming edge
//   corr_valid_i    correction request, corr_dir_i its direction
//   ready_c_o       correction accept (combinational)
//   op_c_o          operation to apply this cycle (decoded from pending register)
module dco_corr_ctl
  import dpll_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     phase_clr_i,
  input  logic     active_i,
  input  logic     toggle_i,
  input  logic     corr_valid_i,
  input  logic     corr_dir_i,
  output logic     ready_c_o,
  output corr_op_t op_c_o
);

  logic pend_q, pend_d;
  logic dir_q, dir_d;
  logic lock_q, lock_d;
  logic accept_c;

  // Reset gating keeps ready low before half_q has a defined value.
  assign ready_c_o = reset_n && !pend_q && !lock_q && active_i && !phase_clr_i;
  assign accept_c  = corr_valid_i && ready_c_o;
  assign op_c_o    = !pend_q ? HOLD : ((dir_q == CORR_RET) ? RET : ADV);

  // Pending lives exactly one cycle; lock holds from apply until the next toggle.
  always_comb begin
    pend_d = 1'b0;
    dir_d  = dir_q;
    lock_d = lock_q;
    if (accept_c) begin
      pend_d = 1'b1;
      dir_d  = corr_dir_i;
    end
    if (phase_clr_i || !active_i || toggle_i) begin
      lock_d = 1'b0;
    end else if (pend_q) begin
      lock_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q <= 1'b0;
      dir_q  <= CORR_ADV;
      lock_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      dir_q  <= dir_d;
      lock_q <= lock_d;
    end
  end

endmodule

// File: rtl/dco_div.sv
// Digitally controlled oscillator divider: clk_out toggles every half_q clk cycles,
// with single-step advance/retard phase corrections through a ready/valid port.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   half_n                requested half-period (0 = stopped), sampled into half_q
//   phase_clr             realign strobe: counter and clk_out to 0
//   corr_valid/corr_dir   correction request (0 = advance, 1 = retard)
//   corr_ready            correction accept
//   clk_out               divided clock (registered)
//   rise_p/fall_p         one-cycle pulses coincident with clk_out edges
//   adv_cnt/ret_cnt       applied-correction counters, only with DCO_DIV_STATUS_EN
// Build option: define DCO_DIV_STATUS_EN to add the saturating status counters.
module dco_div
  import dpll_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned STEP   = 5,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CNT_W-1:0]  half_n,
  input  logic              phase_clr,
  input  logic              corr_valid,
  input  logic              corr_dir,
  output logic              corr_ready,
  output logic              clk_out,
  output logic              rise_p,
  output logic              fall_p
`ifdef DCO_DIV_STATUS_EN
  ,
  output logic [STAT_W-1:0] adv_cnt,
  output logic [STAT_W-1:0] ret_cnt
`endif
);

  localparam int unsigned EXT_W = CNT_W + 1;

  if (STEP < 1) begin : g_step_chk
    $error("dco_div: STEP must be at least 1");
  end
  if (STAT_W < 1) begin : g_stat_chk
    $error("dco_div: STAT_W must be at least 1");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             clk_out_q, clk_out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [EXT_W-1:0] cnt_ext, step_ext, cnt_nxt;
  logic             active_c, toggle_c;
  corr_op_t         op_c;

  dco_corr_ctl u_corr_ctl (
    .clk          (clk),
    .reset_n      (reset_n),
    .phase_clr_i  (phase_clr),
    .active_i     (active_c),
    .toggle_i     (toggle_c),
    .corr_valid_i (corr_valid),
    .corr_dir_i   (corr_dir),
    .ready_c_o    (corr_ready),
    .op_c_o       (op_c)
  );

  // One extra bit so an advance near the top of the range cannot wrap before the compare.
  assign cnt_ext  = {1'b0, cnt_q};
  assign step_ext = EXT_W'(STEP);

  always_comb begin
    cnt_nxt = cnt_ext + EXT_W'(1);
    case (op_c)
      ADV:     cnt_nxt = cnt_ext + EXT_W'(1) + step_ext;
      // Below the floor the counter holds for one cycle instead of wrapping.
      RET:     cnt_nxt = (cnt_ext >= step_ext) ? (cnt_ext + EXT_W'(1) - step_ext) : cnt_ext;
      default: cnt_nxt = cnt_ext + EXT_W'(1);
    endcase
  end

  assign active_c = (half_q != '0);
  assign toggle_c = active_c && (cnt_nxt >= {1'b0, half_q});

  // Next-state: realign > stopped > toggle > count.
  always_comb begin
    cnt_d     = cnt_q;
    half_d    = half_q;
    clk_out_d = clk_out_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    if (phase_clr) begin
      cnt_d     = '0;
      half_d    = half_n;
      clk_out_d = 1'b0;
    end else if (!active_c) begin
      cnt_d  = '0;
      half_d = half_n;
    end else if (toggle_c) begin
      cnt_d     = '0;
      half_d    = half_n;
      clk_out_d = !clk_out_q;
      rise_d    = !clk_out_q;
      fall_d    = clk_out_q;
    end else begin
      cnt_d = cnt_nxt[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      half_q    <= '0;
      clk_out_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      clk_out_q <= clk_out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign clk_out = clk_out_q;
  assign rise_p  = rise_q;
  assign fall_p  = fall_q;

`ifdef DCO_DIV_STATUS_EN
  logic [STAT_W-1:0] adv_q, adv_d;
  logic [STAT_W-1:0] ret_q, ret_d;

  // Count corrections that actually reach the counter, saturating at all-ones.
  always_comb begin
    adv_d = adv_q;
    ret_d = ret_q;
    if (active_c && !phase_clr) begin
      if ((op_c == ADV) && (adv_q != '1)) adv_d = adv_q + STAT_W'(1);
      if ((op_c == RET) && (ret_q != '1)) ret_d = ret_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      adv_q <= '0;
      ret_q <= '0;
    end else begin
      adv_q <= adv_d;
      ret_q <= ret_d;
    end
  end

  assign adv_cnt = adv_q;
  assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_dco_div.sv
// Directed bench for dco_div: table of single-half-period correction cases plus
// hand-written reset, retune, realign and stopped-divider sequences.
module tb_dco_div;
  import dpll_pkg::*;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned STEP   = 5;
  localparam int unsigned STAT_W = 16;
  localparam int          MAXC   = 400;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [CNT_W-1:0] half_n;
  logic             phase_clr;
  logic             corr_valid;
  logic             corr_dir;
  logic             corr_ready;
  logic             clk_out;
  logic             rise_p;
  logic             fall_p;
`ifdef DCO_DIV_STATUS_EN
  logic [STAT_W-1:0] adv_cnt;
  logic [STAT_W-1:0] ret_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dco_div #(
    .CNT_W  (CNT_W),
    .STEP   (STEP),
    .STAT_W (STAT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .half_n     (half_n),
    .phase_clr  (phase_clr),
    .corr_valid (corr_valid),
    .corr_dir   (corr_dir),
    .corr_ready (corr_ready),
    .clk_out    (clk_out),
    .rise_p     (rise_p),
    .fall_p     (fall_p)
`ifdef DCO_DIV_STATUS_EN
    ,
    .adv_cnt    (adv_cnt),
    .ret_cnt    (ret_cnt)
`endif
  );

  // half: half_n; k: cycle (cnt value) in which corr_valid is raised, -1 = none;
  // exp_len: expected length in clk cycles of the first half-period after realign.
  typedef struct {
    int   half;
    int   k;
    logic dir;
    int   exp_len;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Counts negedges until the selected pulse is seen; -1 when the budget runs out.
  task automatic wait_pulse(input bit want_fall, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(want_fall ? fall_p : rise_p) && n < MAXC);
    if (!(want_fall ? fall_p : rise_p)) n = -1;
  endtask

  // Realign with a new half_n; returns in cycle 0 of a low half-period.
  task automatic do_clr(input int h);
    @(negedge clk);
    half_n     = CNT_W'(h);
    phase_clr  = 1'b1;
    corr_valid = 1'b0;
    @(negedge clk);
    phase_clr = 1'b0;
  endtask

  task automatic run_case(input vec_t v, input int idx);
    int c;
    bit got;
    bit lock_ok;
    do_clr(v.half);
    c       = 0;
    got     = 1'b0;
    lock_ok = 1'b1;
    while (c < MAXC && !got) begin
      if (c == v.k) begin
        corr_valid = 1'b1;
        corr_dir   = v.dir;
        #1 chk($sformatf("vec%0d_accept_ready", idx), 32'(corr_ready), 32'd1);
      end else begin
        corr_valid = 1'b0;
        #1 if (v.k >= 0 && c > v.k && corr_ready !== 1'b0) lock_ok = 1'b0;
      end
      @(negedge clk);
      c++;
      if (rise_p) got = 1'b1;
    end
    chk($sformatf("vec%0d_half_len", idx), got ? 32'(c) : 32'hffff_ffff, 32'(v.exp_len));
    if (v.k >= 0) chk($sformatf("vec%0d_ready_locked", idx), 32'(lock_ok), 32'd1);
    #1 chk($sformatf("vec%0d_ready_after_toggle", idx), 32'(corr_ready), 32'd1);
  endtask

  initial begin
    int n;
    int exp_adv;
    int exp_ret;
    bit stop_ok;
`ifdef DCO_DIV_STATUS_EN
    logic [STAT_W-1:0] adv0, ret0;
`endif

    vecs[0]  = '{4,   -1,  CORR_ADV, 4};
    vecs[1]  = '{1,   -1,  CORR_ADV, 1};
    vecs[2]  = '{20,  3,   CORR_ADV, 15};
    vecs[3]  = '{20,  12,  CORR_ADV, 15};
    vecs[4]  = '{20,  13,  CORR_ADV, 15};
    vecs[5]  = '{20,  16,  CORR_ADV, 18};
    vecs[6]  = '{20,  2,   CORR_RET, 21};
    vecs[7]  = '{20,  10,  CORR_RET, 25};
    vecs[8]  = '{20,  0,   CORR_RET, 21};
    vecs[9]  = '{20,  3,   CORR_RET, 21};
    vecs[10] = '{20,  4,   CORR_RET, 25};
    vecs[11] = '{255, 250, CORR_ADV, 252};

    reset_n    = 1'b0;
    half_n     = CNT_W'(4);
    phase_clr  = 1'b0;
    corr_valid = 1'b0;
    corr_dir   = CORR_ADV;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_rise_p", 32'(rise_p), 32'd0);
    chk("rst_fall_p", 32'(fall_p), 32'd0);
    chk("rst_corr_ready", 32'(corr_ready), 32'd0);
`ifdef DCO_DIV_STATUS_EN
    chk("rst_adv_cnt", 32'(adv_cnt), 32'd0);
    chk("rst_ret_cnt", 32'(ret_cnt), 32'd0);
`endif

    // First toggle half_q+1 cycles after reset release, then 4/4 steady state.
    reset_n = 1'b1;
    wait_pulse(1'b0, n);
    chk("first_rise_after_reset", 32'(n), 32'd5);
    chk("clk_out_high", 32'(clk_out), 32'd1);
    @(negedge clk);
    chk("rise_p_one_cycle", 32'(rise_p), 32'd0);
    wait_pulse(1'b1, n);
    chk("rise_to_fall", 32'(n), 32'd3);
    chk("clk_out_low", 32'(clk_out), 32'd0);
    wait_pulse(1'b0, n);
    chk("fall_to_rise", 32'(n), 32'd4);

    // Table of correction cases.
`ifdef DCO_DIV_STATUS_EN
    adv0 = adv_cnt;
    ret0 = ret_cnt;
`endif
    exp_adv = 0;
    exp_ret = 0;
    for (int i = 0; i < 12; i++) begin
      run_case(vecs[i], i);
      if (vecs[i].k >= 0) begin
        if (vecs[i].dir == CORR_ADV) exp_adv++;
        else exp_ret++;
      end
    end
`ifdef DCO_DIV_STATUS_EN
    chk("adv_cnt_delta", 32'(adv_cnt - adv0), 32'(exp_adv));
    chk("ret_cnt_delta", 32'(ret_cnt - ret0), 32'(exp_ret));
`endif

    // half_n 8 -> 3 mid half-period: current finishes at 8, then 3s.
    do_clr(8);
    repeat (3) @(negedge clk);
    half_n = CNT_W'(3);
    wait_pulse(1'b0, n);
    chk("retune_cur_half", 32'(n + 3), 32'd8);
    wait_pulse(1'b1, n);
    chk("retune_next_half", 32'(n), 32'd3);
    wait_pulse(1'b0, n);
    chk("retune_third_half", 32'(n), 32'd3);

    // Realign while a correction is pending and another is offered.
    do_clr(20);
    wait_pulse(1'b0, n);
    repeat (2) @(negedge clk);
    corr_valid = 1'b1;
    corr_dir   = CORR_ADV;
`ifdef DCO_DIV_STATUS_EN
    adv0 = adv_cnt;
`endif
    @(negedge clk);
    chk("clr_pre_clk_out", 32'(clk_out), 32'd1);
    phase_clr  = 1'b1;
    corr_valid = 1'b1;
    #1 chk("clr_ready_low", 32'(corr_ready), 32'd0);
    @(negedge clk);
    phase_clr  = 1'b0;
    corr_valid = 1'b0;
    chk("clr_clk_out", 32'(clk_out), 32'd0);
    chk("clr_no_fall_p", 32'(fall_p), 32'd0);
    wait_pulse(1'b0, n);
    chk("clr_no_corr_len", 32'(n), 32'd20);
`ifdef DCO_DIV_STATUS_EN
    chk("clr_adv_cnt_same", 32'(adv_cnt), 32'(adv0));
`endif

    // Stopped divider, then restart from half_q == 0.
    do_clr(0);
    stop_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 if (clk_out !== 1'b0 || rise_p !== 1'b0 || fall_p !== 1'b0 || corr_ready !== 1'b0)
        stop_ok = 1'b0;
      @(negedge clk);
    end
    chk("stopped_quiet", 32'(stop_ok), 32'd1);
    half_n = CNT_W'(5);
    wait_pulse(1'b0, n);
    chk("restart_first_rise", 32'(n), 32'd6);

    // Reset mid high half-period with a correction in flight.
    do_clr(6);
    wait_pulse(1'b0, n);
    repeat (2) @(negedge clk);
    corr_valid = 1'b1;
    corr_dir   = CORR_RET;
    @(negedge clk);
    corr_valid = 1'b0;
    reset_n    = 1'b0;
    @(negedge clk);
    chk("midrst_clk_out", 32'(clk_out), 32'd0);
    chk("midrst_rise_p", 32'(rise_p), 32'd0);
    chk("midrst_fall_p", 32'(fall_p), 32'd0);
    chk("midrst_ready", 32'(corr_ready), 32'd0);
`ifdef DCO_DIV_STATUS_EN
    chk("midrst_ret_cnt", 32'(ret_cnt), 32'd0);
`endif
    reset_n = 1'b1;
    wait_pulse(1'b0, n);
    chk("midrst_first_rise", 32'(n), 32'd7);
    wait_pulse(1'b1, n);
    chk("midrst_next_half", 32'(n), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
